// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RV32M encodings for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  function automatic logic is_mul_op(input logic [2:0] f3);
    return ~f3[2];
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// Restoring unsigned divider datapath: one quotient bit per step_i, magnitudes only.
module ex_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            init_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_next_o,
  output logic [XLEN-1:0] rem_next_o
);

  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [XLEN:0]   shifted, diff;

  // diff[XLEN] is the borrow: set means the trial subtraction must be undone
  assign shifted    = {rem_q, quo_q[XLEN-1]};
  assign diff       = shifted - {1'b0, div_q};
  assign quo_next_o = {quo_q[XLEN-2:0], ~diff[XLEN]};
  assign rem_next_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    if (init_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      div_d = divisor_i;
    end else if (step_i) begin
      rem_d = rem_next_o;
      quo_d = quo_next_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage; stalls the pipe via busy while iterating.
// Define MULDIV_FAST_MUL_EN for a single-cycle registered 33x33 multiply instead of shift-add.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
`ifndef MULDIV_FAST_MUL_EN
  localparam logic [1:0] MUL  = 2'd1;
`endif
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;

  logic            is_mul, is_rem, sa, sb, div_special;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  assign is_mul = is_mul_op(funct3);
  assign is_rem = funct3[1];
  assign sa     = op_a[XLEN-1] & (is_mul ? (funct3 != FUNCT3_MULHU) : ~funct3[0]);
  assign sb     = op_b[XLEN-1] & (is_mul ? ~funct3[1] : ~funct3[0]);
  assign abs_a  = sa ? -op_a : op_a;
  assign abs_b  = sb ? -op_b : op_b;

  // Divide-by-zero and signed MIN/-1 bypass the iterative divider
  assign div_special = (op_b == '0) ||
                       (~funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1);
  assign special_res = (op_b == '0) ? (is_rem ? op_a : '1) : (is_rem ? '0 : op_a);

  logic            div_init, div_step;
  logic [XLEN-1:0] div_quo, div_rem, quo_fix, rem_fix, div_res;

  ex_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk_i     (clock),
    .rst_ni    (reset),
    .init_i    (div_init),
    .step_i    (div_step),
    .dividend_i(abs_a),
    .divisor_i (abs_b),
    .quo_next_o(div_quo),
    .rem_next_o(div_rem)
  );

  assign quo_fix = neg_q ? -div_quo : div_quo;
  assign rem_fix = neg_q ? -div_rem : div_rem;
  assign div_res = op_q[1] ? rem_fix : quo_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_full;
  logic [XLEN-1:0]          fast_res;

  assign fast_a    = {sa, op_a};
  assign fast_b    = {sb, op_b};
  assign fast_full = fast_a * fast_b;
  assign fast_res  = (funct3 == FUNCT3_MUL) ? fast_full[XLEN-1:0] : fast_full[2*XLEN-1:XLEN];
`else
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d, prod_step, prod_fix;
  logic [XLEN:0]     prod_sum;
  logic [XLEN-1:0]   mul_res;

  // Multiplier sits in the low half and shifts out as the product shifts in
  assign prod_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {prod_sum, prod_q[XLEN-1:1]};
  assign prod_fix  = neg_q ? -prod_step : prod_step;
  assign mul_res   = (op_q == FUNCT3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    div_init = 1'b0;
    div_step = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
    mcand_d  = mcand_q;
    prod_d   = prod_q;
`endif
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d  = funct3;
            neg_d = (is_mul || !is_rem) ? (sa ^ sb) : sa;
            if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
              result_d = fast_res;
              state_d  = FIN;
`else
              mcand_d  = abs_a;
              prod_d   = {{XLEN{1'b0}}, abs_b};
              state_d  = MUL;
`endif
            end else if (div_special) begin
              result_d = special_res;
              state_d  = FIN;
            end else begin
              div_init = 1'b1;
              state_d  = DIV;
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        MUL: begin
          prod_d = prod_step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            result_d = mul_res;
            state_d  = FIN;
          end
        end
`endif
        DIV: begin
          div_step = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            result_d = div_res;
            state_d  = FIN;
          end
        end
        FIN: begin
          if (!ex_stall) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q  <= '0;
      prod_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
`endif
    end
  end

  assign busy   = (state_q == DIV) || (state_q == 2'd1);
  assign done   = (state_q == FIN);
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start, ex_stall, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat  = 1;
  localparam int MulBusy = 0;
`else
  localparam int MulLat  = 33;
  localparam int MulBusy = 32;
`endif

  ex_muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .ex_stall(ex_stall),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clock = ~clock;

  // Launch one op and return cycles until done (lat) and cycles with busy high.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int lat, output int bcnt);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_mul();
    int lat, bc;
    run_op(FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, bc);
    checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", result); end
    checks++; if (lat != MulLat) begin errors++; $display("FAIL mul_latency got %0d want %0d", lat, MulLat); end
    checks++; if (bc != MulBusy) begin errors++; $display("FAIL mul_busy_cycles got %0d want %0d", bc, MulBusy); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_fin_exit got done=%b want 0", done); end
  endtask

  task automatic test_mulh();
    logic [2:0]  f   [3] = '{FUNCT3_MULHU, FUNCT3_MULH, FUNCT3_MULHSU};
    logic [31:0] a   [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] b   [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(f[i], a[i], b[i], 1'b0, lat, bc);
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL mulh_result[%0d] got %h want %h", i, result, exp[i]); end
      checks++; if (lat != MulLat) begin errors++; $display("FAIL mulh_latency[%0d] got %0d want %0d", i, lat, MulLat); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_div();
    logic [2:0]  f   [3] = '{FUNCT3_DIV, FUNCT3_REM, FUNCT3_DIVU};
    logic [31:0] a   [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
    logic [31:0] b   [3] = '{32'd2, 32'd2, 32'd7};
    logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(f[i], a[i], b[i], 1'b0, lat, bc);
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, result, exp[i]); end
      checks++; if (lat != 33 || bc != 32) begin errors++; $display("FAIL div_timing[%0d] got lat=%0d busy=%0d want 33/32", i, lat, bc); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f   [3] = '{FUNCT3_DIVU, FUNCT3_REMU, FUNCT3_DIV};
    logic [31:0] a   [3] = '{32'd5, 32'd5, 32'h8000_0000};
    logic [31:0] b   [3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(f[i], a[i], b[i], 1'b0, lat, bc);
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL special_result[%0d] got %h want %h", i, result, exp[i]); end
      checks++; if (lat != 1 || bc != 0) begin errors++; $display("FAIL special_timing[%0d] got lat=%0d busy=%0d want 1/0", i, lat, bc); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stall();
    int lat, bc;
    run_op(FUNCT3_DIVU, 32'd100, 32'd7, 1'b1, lat, bc);
    checks++; if (lat != 33) begin errors++; $display("FAIL stall_latency got %0d want 33", lat); end
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      checks++; if (done !== 1'b1 || result !== 32'd14) begin errors++; $display("FAIL stall_hold[%0d] got done=%b result=%h want 1/0000000e", k, done, result); end
    end
    ex_stall = 1'b0;
    @(posedge clock); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_release got done=%b busy=%b want 0/0", done, busy); end
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_flush();
    int n;
    funct3 = FUNCT3_DIV; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b want 1", busy); end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_idle got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_result got %h want 0000000e", result); end
    n = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) n++;
    end
    checks++; if (n != 0 || result !== 32'd14) begin errors++; $display("FAIL flush_quiet got active=%0d result=%h want 0/0000000e", n, result); end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    funct3 = FUNCT3_DIV; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_ctrl got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL areset_result got %h want 0", result); end
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #1;
    run_op(FUNCT3_MUL, 32'd3, 32'd5, 1'b0, lat, bc);
    checks++; if (result !== 32'd15 || lat != MulLat) begin errors++; $display("FAIL areset_recover got result=%h lat=%0d want 0000000f/%0d", result, lat, MulLat); end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_special();
    test_stall();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
